// File: rtl/spi_flash_reader.sv
// SPI READ (0x03) initiator: sends {0x03, addr} once, then streams len bytes
// from MISO to a valid/ready byte port. Mode 0, MSB first. SCK is stretched
// while the single output byte is still unaccepted.
module spi_flash_reader #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        start,
  input  logic [23:0] addr,
  input  logic [15:0] len,
  output logic        busy,
  output logic        done,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic        flash_csb,
  output logic        flash_clk,
  output logic        flash_io0,
  input  logic        flash_io1
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_OUT,
    SHIFT_IN,
    WAIT_BUF,
    CS_HOLD,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic        sck_q, sck_d;
  logic        csb_q, csb_d;
  logic [4:0]  bit_q, bit_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] sr_q, sr_d;
  logic [7:0]  rx_q, rx_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;

  logic [31:0] cmd_word;
  logic        div_last;

  assign cmd_word = {8'h03, addr};
  assign div_last = (div_q == DIV_LAST);

  // MOSI is the MSB of the command shifter; after 32 shifts it holds zeros,
  // which gives the required low level during SHIFT_IN without a separate reg.
  assign flash_io0 = sr_q[31];
  assign flash_clk = sck_q;
  assign flash_csb = csb_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign busy      = (state_q != IDLE) && (state_q != DONE);
  assign done      = (state_q == DONE);

  // State and datapath registers with synchronous reset.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= IDLE;
      div_q      <= '0;
      sck_q      <= 1'b0;
      csb_q      <= 1'b1;
      bit_q      <= '0;
      cnt_q      <= '0;
      sr_q       <= '0;
      rx_q       <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      sck_q      <= sck_d;
      csb_q      <= csb_d;
      bit_q      <= bit_d;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      rx_q       <= rx_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Next-state logic: bit-cell timing, shifting, byte hand-off and stalls.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    sck_d      = sck_q;
    csb_d      = csb_q;
    bit_d      = bit_q;
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    rx_d       = rx_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;

    if (rd_valid_q && rd_ready) begin
      rd_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          if (len != 16'd0) begin
            state_d = SHIFT_OUT;
            csb_d   = 1'b0;
            sr_d    = cmd_word;
            cnt_d   = len;
            div_d   = '0;
            sck_d   = 1'b0;
            bit_d   = '0;
          end else begin
            state_d = DONE;
          end
        end
      end

      SHIFT_OUT: begin
        if (!div_last) begin
          div_d = div_q + 8'd1;
        end else if (!sck_q) begin
          sck_d = 1'b1;
          div_d = '0;
        end else begin
          sck_d = 1'b0;
          div_d = '0;
          sr_d  = {sr_q[30:0], 1'b0};
          if (bit_q == 5'd31) begin
            state_d = SHIFT_IN;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 5'd1;
          end
        end
      end

      SHIFT_IN: begin
        if (!div_last) begin
          div_d = div_q + 8'd1;
        end else if (!sck_q) begin
          div_d = '0;
          if ((bit_q == 5'd0) && rd_valid_q) begin
            state_d = WAIT_BUF;
          end else begin
            sck_d = 1'b1;
            rx_d  = {rx_q[6:0], flash_io1};
          end
        end else begin
          sck_d = 1'b0;
          div_d = '0;
          if (bit_q == 5'd7) begin
            bit_d      = '0;
            rd_data_d  = rx_q;
            rd_valid_d = 1'b1;
            cnt_d      = cnt_q - 16'd1;
            if (cnt_q == 16'd1) begin
              state_d = CS_HOLD;
            end
          end else begin
            bit_d = bit_q + 5'd1;
          end
        end
      end

      WAIT_BUF: begin
        if (!rd_valid_q) begin
          state_d = SHIFT_IN;
          div_d   = '0;
        end
      end

      CS_HOLD: begin
        if (!div_last) begin
          div_d = div_q + 8'd1;
        end else if (!rd_valid_q) begin
          csb_d   = 1'b1;
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: doc/spi_flash_reader.md
# spi_flash_reader

SPI READ-command (0x03) initiator placed inside the user project area. It fetches a burst of bytes from the external SPI flash that the caravan bench models with `spiflash`, and streams them to user logic over a valid/ready byte interface. It is the controller side of the flash link; the flash model is the responder. Single-lane SPI mode 0, MSB first, with clock stretching for backpressure.

## Interface
- `CLK_DIV`, default 2: SCK half-period in `wb_clk_i` cycles. Legal range 1..255. SCK frequency is `wb_clk_i`/(2·CLK_DIV).
- `wb_clk_i` in 1: the single clock.
- `wb_rst_i` in 1: reset, synchronous and active-high.
- `start` in 1: request pulse. Sampled only while `busy`=0.
- `addr` in 24: flash byte address. Latched on an accepted `start`.
- `len` in 16: byte count. Latched on an accepted `start`. 0 is legal.
- `busy` out 1: high from the cycle after an accepted `start` until the cycle of `done`.
- `done` out 1: one-cycle completion pulse.
- `rd_data` out 8: received byte.
- `rd_valid` out 1: `rd_data` is held stable while this is high.
- `rd_ready` in 1: consumer accepts the byte when `rd_valid`&&`rd_ready`.
- `flash_csb` out 1: chip select, active-low.
- `flash_clk` out 1: SCK, idles low.
- `flash_io0` out 1: MOSI.
- `flash_io1` in 1: MISO.

## Operation
- **Reset** (takes effect at the next edge, including mid-transfer): `flash_csb`=1, `flash_clk`=0, `flash_io0`=0, `busy`=0, `done`=0, `rd_valid`=0, `rd_data`=0, state IDLE. The partial transfer is abandoned and nothing is emitted afterward.
- **States:** IDLE, SHIFT_OUT, SHIFT_IN, WAIT_BUF, CS_HOLD, DONE.
- **IDLE:**
  - `start`=1 with `len`≠0: go to SHIFT_OUT. `flash_csb`=0 and `flash_io0`=bit 31 of the shift word {8'h03, addr} on the next cycle.
  - `start`=1 with `len`=0: go to DONE directly. `flash_csb` never drops.
- **Bit cell** (both shift states):
  - SCK low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - MISO is sampled in the cycle SCK goes 1 (rising edge).
  - `flash_io0` changes only in the cycle SCK goes 0 (falling edge).
- **SHIFT_OUT:** 32 bits, MSB first, then SHIFT_IN. `flash_io0` is driven 0 during SHIFT_IN.
- **SHIFT_IN:**
  - 8 bits per byte, MSB first, into an internal shift register.
  - On the 8th falling edge the byte is copied to `rd_data`, `rd_valid` is set, and the remaining count is decremented.
  - If the count is now 0, go to CS_HOLD.
- **Backpressure:** before starting the first rising edge of the next byte, if `rd_valid` is still 1 the block enters WAIT_BUF. There SCK is held low and `flash_csb` stays low until the byte is accepted, then the bit cell resumes with a full CLK_DIV low phase.
- **Byte accept:** `rd_valid`&&`rd_ready` clears `rd_valid` on the next edge. A new byte completing in the same cycle is impossible by construction: at most one byte is buffered.
- **CS_HOLD:** SCK low for CLK_DIV cycles. It exits only when `rd_valid`=0 (last byte accepted), then `flash_csb`=1 and go to DONE.
- **DONE:** `done`=1 and `busy`=0 for one cycle, then IDLE. A `start` presented during the DONE cycle is ignored.
- **start while busy:** ignored. It is not queued.
- **Address:** auto-increment is the flash's responsibility; the block sends the address once. `len` up to 65535 is supported, with no wrap handling of the flash address.

## Timing
Cycle 0 is the edge on which `start` is accepted, with CLK_DIV=2.
- Cycle 1: `flash_csb`=0, `busy`=1, `flash_io0`=bit 31 (0).
- Rising edge of bit k (k=0 is the first command bit) at cycle 1+CLK_DIV+2k·CLK_DIV; falling edge at 1+2(k+1)·CLK_DIV.
- First data byte has k=32..39. Last rising edge at cycle 159. `rd_valid`=1 at cycle 161.
- For `len`=1 with `rd_ready`=1: `rd_valid` clears at 162, `flash_csb`=1 at 163, `done` at cycle 163 (the first cycle with `flash_csb` high and `busy`=0).
- Each further byte with no stall adds 16·CLK_DIV cycles.
- `len`=0: `done` at cycle 1, `busy` stays 0.

## Test plan
- **Reset:** hold `wb_rst_i` 5 cycles with all inputs toggling. Expect `flash_csb`=1, `flash_clk`=0, `flash_io0`=0, `busy`=`done`=`rd_valid`=0 every cycle.
- **Single byte:** flash model holds 8'hA5 at 24'h000010; `start` with `len`=1, `rd_ready`=1. Expect `flash_io0` to carry 0x03,0x00,0x00,0x10 on rising edges, `rd_data`=8'hA5 with `rd_valid` at cycle 161, and `done` at cycle 163.
- **Burst:** bytes 11,22,33,44 at 24'h000100; `len`=4, `rd_ready`=1. Expect four accepts in order, 32 cycles apart, and a single `flash_csb` low window.
- **Backpressure:** `len`=2, `rd_ready`=0 for 50 cycles after the first `rd_valid`. Expect SCK low and `flash_csb` low throughout, `rd_data` stable, the second byte correct, and no rising-edge count beyond 40 during the stall.
- **Zero length and busy:** `len`=0 gives `done` at cycle 1 with no SCK and no CSB activity. A `start` pulsed mid-burst is ignored, so total rising edges equal 32+8·`len`.
- **Mid-transfer reset:** `wb_rst_i` at cycle 80 of a `len`=4 read gives `flash_csb`=1 the next cycle and no `rd_valid` afterward. A new `start` then completes correctly.
